// File: rtl/issue_stage.sv
`timescale 1ns/1ps
// issue_stage: owns the fetch PC, captures opcode/immediate words from the
// fetcher, decodes the instruction length, advances the PC and hands captured
// instructions to execute through a single-entry valid/ready register.
// An execute-side redirect overrides sequencing and flushes the pending entry.
//
// Optional feature macro: ISSUE_TRAP_EN
//   defined   : opcode 16'h0000 is illegal; it issues with out_illegal=1 and
//               the stage halts until a redirect.
//   undefined : out_illegal is tied low and 16'h0000 is an ordinary
//               2-byte instruction.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   pc                  registered fetch PC presented to the fetcher
//   f_ready/f_ins/f_imm fetcher window for the current pc
//   redirect_valid/_pc  execute-side PC override
//   out_valid/out_ready output handshake
//   out_pc/out_ins/out_imm/out_len/out_illegal  issued instruction
module issue_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  input  logic        f_ready,
  input  logic [15:0] f_ins,
  input  logic [31:0] f_imm,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [15:0] out_ins,
  output logic [31:0] out_imm,
  output logic [2:0]  out_len,
  output logic        out_illegal
);

  localparam int unsigned PC_W  = 64;
  localparam int unsigned INS_W = 16;
  localparam int unsigned IMM_W = 32;
  localparam int unsigned LEN_W = 3;

`ifdef ISSUE_TRAP_EN
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALT   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_FETCH  = 2'd1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic [INS_W-1:0]   out_ins_q, out_ins_d;
  logic [IMM_W-1:0]   out_imm_q, out_imm_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;

  logic               slot_free_c;
  logic               long_c;
  logic [LEN_W-1:0]   len_c;

`ifdef ISSUE_TRAP_EN
  logic               out_illegal_q, out_illegal_d;
  logic               illegal_c;
`endif

  // Length decode: bit 0 of the opcode word selects the 6-byte form.
  always_comb begin
    long_c      = f_ins[0];
    len_c       = long_c ? LEN_W'(6) : LEN_W'(2);
    slot_free_c = !out_valid_q || out_ready;
  end

`ifdef ISSUE_TRAP_EN
  always_comb illegal_c = (f_ins == INS_W'(0));
`endif

  // Next-state, PC sequencing and output register update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_ins_d   = out_ins_q;
    out_imm_d   = out_imm_q;
    out_len_d   = out_len_q;
`ifdef ISSUE_TRAP_EN
    out_illegal_d = out_illegal_q;
`endif

    if (redirect_valid) begin
      // Redirect wins: new PC, pending entry dropped, capture suppressed.
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      state_d     = ST_SETTLE;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      unique case (state_q)
        // Fetcher ready is stale for one cycle after pc moves.
        ST_SETTLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (f_ready && slot_free_c) begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_ins_d   = f_ins;
            out_imm_d   = long_c ? f_imm : IMM_W'(0);
            out_len_d   = len_c;
`ifdef ISSUE_TRAP_EN
            out_illegal_d = illegal_c;
            if (illegal_c) begin
              state_d = ST_HALT;
            end else begin
              pc_d    = pc_q + PC_W'(len_c);
              state_d = ST_SETTLE;
            end
`else
            pc_d    = pc_q + PC_W'(len_c);
            state_d = ST_SETTLE;
`endif
          end
        end
`ifdef ISSUE_TRAP_EN
        ST_HALT: state_d = ST_HALT;
`endif
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ins_q   <= '0;
      out_imm_q   <= '0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_ins_q   <= out_ins_d;
      out_imm_q   <= out_imm_d;
      out_len_q   <= out_len_d;
    end
  end

`ifdef ISSUE_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_illegal_q <= 1'b0;
    end else begin
      out_illegal_q <= out_illegal_d;
    end
  end
  assign out_illegal = out_illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

  assign pc        = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_ins   = out_ins_q;
  assign out_imm   = out_imm_q;
  assign out_len   = out_len_q;

endmodule
